// File: rtl/mem_req_fifo_pkg.sv
// Request type and sizing constants shared by the memory-side request path.
package mem_req_fifo_pkg;

   localparam int ADDR_FIELD_WIDTH   = 32;
   localparam int DATA_FIELD_WIDTH   = 64;
   localparam int BYTE               = 8;
   localparam int NUM_CORES          = 4;
   localparam int MEM_REQ_FIFO_DEPTH = 8;

   typedef enum logic [1:0] {
      OP_RD     = 2'd0,
      OP_WR     = 2'd1,
      OP_ATOMIC = 2'd2,
      OP_FLUSH  = 2'd3
   } opcode_e;

   typedef struct packed {
      logic                               valid;
      logic [$clog2(NUM_CORES)-1:0]       core_id;
      opcode_e                            opcode;
      logic [ADDR_FIELD_WIDTH-1:0]        addr;
      logic [DATA_FIELD_WIDTH-1:0]        data;
      logic [DATA_FIELD_WIDTH/BYTE-1:0]   be;
   } request_t;

endpackage

// File: rtl/req_fifo_ram.sv
// Request storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the occupancy count.
module req_fifo_ram
   import mem_req_fifo_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  request_t                 wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output request_t                 rdata_o
);

   request_t mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_req_fifo.sv
// Elastic first-word-fall-through buffer between interconnect and memory controller.
// Requests presented while full are dropped, flagged sticky and counted (saturating).
module mem_req_fifo
   import mem_req_fifo_pkg::*;
#(
   parameter int DEPTH      = MEM_REQ_FIFO_DEPTH,
   parameter int AFULL_TH   = 6,
   parameter int DROP_CNT_W = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  request_t                in_req,
   output logic                    in_ready,
   output request_t                out_req,
   input  logic                    out_ready,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    empty,
   output logic                    full,
   output logic                    almost_full,
   output logic                    overflow_err,
   output logic [DROP_CNT_W-1:0]   drop_cnt
);

   localparam int            PW      = $clog2(DEPTH);
   localparam int            CW      = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic [DROP_CNT_W-1:0] drop_q, drop_d;

   logic     push, pop, drop;
   request_t ram_rdata;

   assign empty       = (count_q == '0);
   assign full        = (count_q == DEPTH_C);
   assign almost_full = (count_q >= AFULL_C);
   assign in_ready    = !full;

   assign push = in_req.valid && in_ready;
   assign pop  = !empty && out_ready;
   assign drop = in_req.valid && !in_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      drop_d   = drop_q;

      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // An upstream that ignores backpressure re-presents each cycle, so every cycle counts.
      if (drop) begin
         ovf_d = 1'b1;
         if (drop_q != '1) drop_d = drop_q + DROP_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         drop_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
      end
   end

   req_fifo_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (in_req),
      .raddr_i (rd_ptr_q),
      .rdata_o (ram_rdata)
   );

   assign out_req      = empty ? '0 : ram_rdata;
   assign count        = count_q;
   assign overflow_err = ovf_q;
   assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_mem_req_fifo.sv
// Self-checking bench for mem_req_fifo: occupancy model plus a scoreboard of expected pops.
module tb_mem_req_fifo;
   import mem_req_fifo_pkg::*;

   localparam int DEPTH    = 8;
   localparam int AFULL_TH = 6;
   localparam int DCW      = 8;
   localparam int DROP_MAX = (1 << DCW) - 1;

   logic           clk = 1'b0;
   logic           reset;
   request_t       in_req;
   logic           in_ready;
   request_t       out_req;
   logic           out_ready;
   logic [3:0]     count;
   logic           empty, full, almost_full, overflow_err;
   logic [DCW-1:0] drop_cnt;

   int       tests_run    = 0;
   int       tests_failed = 0;
   request_t sb_q[$];
   int       model_cnt;
   int       model_drop;
   logic     model_ovf;
   int       pushed;

   always #5 clk = ~clk;

   mem_req_fifo #(
      .DEPTH      (DEPTH),
      .AFULL_TH   (AFULL_TH),
      .DROP_CNT_W (DCW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_req       (in_req),
      .in_ready     (in_ready),
      .out_req      (out_req),
      .out_ready    (out_ready),
      .count        (count),
      .empty        (empty),
      .full         (full),
      .almost_full  (almost_full),
      .overflow_err (overflow_err),
      .drop_cnt     (drop_cnt)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic request_t mk_req(input logic [31:0] addr);
      request_t r;
      r.valid   = 1'b1;
      r.core_id = 2'($urandom_range(0, 3));
      r.opcode  = opcode_e'($urandom_range(0, 3));
      r.addr    = addr;
      r.data    = {$urandom, $urandom};
      r.be      = 8'($urandom);
      return r;
   endfunction

   task automatic model_reset();
      sb_q.delete();
      model_cnt  = 0;
      model_drop = 0;
      model_ovf  = 1'b0;
   endtask

   task automatic check_flags();
      check("count",       128'(count),            128'(model_cnt));
      check("empty",       128'(empty),            128'(model_cnt == 0));
      check("full",        128'(full),             128'(model_cnt == DEPTH));
      check("almost_full", 128'(almost_full),      128'(model_cnt >= AFULL_TH));
      check("in_ready",    128'(in_ready),         128'(model_cnt < DEPTH));
      check("out_valid",   128'(out_req.valid),    128'(model_cnt > 0));
      check("drop_cnt",    128'(drop_cnt),         128'(model_drop));
      check("overflow",    128'(overflow_err),     128'(model_ovf));
      if (model_cnt == 0) check("out_zero", 128'(out_req), 128'(0));
   endtask

   // One clock: check state, drive inputs, advance the model, step past the edge.
   task automatic cycle(input logic v, input logic [31:0] addr, input logic ordy);
      request_t r;
      request_t exp_r;
      logic     do_push, do_pop;
      check_flags();
      r         = v ? mk_req(addr) : '0;
      in_req    = r;
      out_ready = ordy;
      do_push   = v && (model_cnt < DEPTH);
      do_pop    = ordy && (model_cnt > 0);
      if (do_pop) begin
         exp_r = sb_q.pop_front();
         check("pop_data", 128'(out_req), 128'(exp_r));
      end
      if (do_push) sb_q.push_back(r);
      if (v && !do_push) begin
         model_ovf = 1'b1;
         if (model_drop < DROP_MAX) model_drop++;
      end
      model_cnt = model_cnt + int'(do_push) - int'(do_pop);
      @(posedge clk);
      #1;
   endtask

   initial begin
      model_reset();
      out_ready = 1'b0;
      reset     = 1'b0;
      in_req    = mk_req(32'h0BAD);

      // Reset held with a valid request presented
      repeat (3) begin
         @(posedge clk);
         #1;
         check_flags();
      end
      reset = 1'b1;

      // Fill then drain
      for (int i = 0; i < 8; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b0);
      for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1);
      check_flags();

      // Write-to-output latency
      cycle(1'b1, 32'h2A0, 1'b0);
      check("lat_valid", 128'(out_req.valid), 128'(1));
      check("lat_addr",  128'(out_req.addr),  128'(32'h2A0));

      // Simultaneous push and pop at count=4
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'h2A1 + 32'(i), 1'b0);
      cycle(1'b1, 32'h2B0, 1'b1);
      check("simul4_count", 128'(count), 128'(4));

      // Simultaneous push and pop at full
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'h2C0 + 32'(i), 1'b0);
      cycle(1'b1, 32'h2F0, 1'b1);
      check("simul8_count", 128'(count),        128'(7));
      check("simul8_drop",  128'(drop_cnt),     128'(1));
      check("simul8_ovf",   128'(overflow_err), 128'(1));

      // Drop counter saturation
      cycle(1'b1, 32'h2F1, 1'b0);
      for (int i = 0; i < 300; i++) cycle(1'b1, 32'h3FF, 1'b0);
      check("sat_drop", 128'(drop_cnt),     128'(255));
      check("sat_ovf",  128'(overflow_err), 128'(1));
      for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1);

      // Streaming across pointer wrap with random backpressure
      pushed = 0;
      for (int it = 0; it < 200 && pushed < 20; it++) begin
         logic acc;
         acc = (model_cnt < DEPTH);
         cycle(1'b1, 32'h400 + 32'(pushed), 1'($urandom_range(0, 1)));
         if (acc) pushed++;
      end
      check("wrap_pushes", 128'(pushed), 128'(20));
      for (int i = 0; i < 16 && model_cnt > 0; i++) cycle(1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 5; i++) cycle(1'b1, 32'h480 + 32'(i), 1'b0);
      check_flags();

      // Asynchronous reset between clock edges
      #2;
      reset = 1'b0;
      #1;
      check("async_count",    128'(count),         128'(0));
      check("async_valid",    128'(out_req.valid), 128'(0));
      check("async_empty",    128'(empty),         128'(1));
      check("async_in_ready", 128'(in_ready),      128'(1));
      check("async_ovf",      128'(overflow_err),  128'(0));
      check("async_drop",     128'(drop_cnt),      128'(0));
      model_reset();
      in_req = '0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      cycle(1'b1, 32'h500, 1'b0);
      cycle(1'b0, 32'h0, 1'b1);
      check_flags();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
